// File: rtl/y_pc_seq_if.sv
// Bundle between the program-counter sequencer and its fetch/execute environment.
// The environment (master) drives control and fetch results; the sequencer (slave) drives pc and status.
interface y_pc_seq_if;
  logic        start;
  logic        stall;
  logic [31:0] ins;
  logic [31:0] PCp4;
  logic        zero;
  logic [31:0] PCin;
  logic        running;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  modport master (
    output start, stall, ins, PCp4, zero,
    input  PCin, running, halted, fault, retired
  );

  modport slave (
    input  start, stall, ins, PCp4, zero,
    output PCin, running, halted, fault, retired
  );
endinterface

// File: rtl/y_pc_seq.sv
// Program-counter sequencer: steps pc through sequential, branch and jump flow,
// retires one instruction per unstalled RUN edge, and stops on halt or watchdog expiry.
module y_pc_seq #(
  parameter logic [31:0] ENTRY   = 32'd128,
  parameter logic [15:0] MAX_INS = 16'd1000
) (
  input  logic       clk,
  input  logic       rst_n,
  y_pc_seq_if.slave  bus,
  output logic [1:0] dbg_state
);

  // Handshake: start is a one-cycle request honoured only outside RUN; stall is a
  // level-sensitive hold while in RUN. There is no ready/ack return path.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [15:0] ret_q;
  logic        running_q;
  logic        halted_q;
  logic        fault_q;

  logic [5:0]  opcode;
  logic        is_jump;
  logic        is_taken;
  logic        is_halt;
  logic        wd_hit;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic [15:0] ret_inc;

  always_comb begin
    opcode   = bus.ins[31:26];
    is_jump  = (opcode == 6'h02) || (opcode == 6'h03);
    is_taken = ((opcode == 6'h04) && bus.zero) || ((opcode == 6'h05) && !bus.zero);
    is_halt  = (bus.ins == 32'h0000000C);
    br_off   = {{14{bus.ins[15]}}, bus.ins[15:0], 2'b00};
    next_pc  = bus.PCp4;
    if (is_jump) begin
      next_pc = {bus.PCp4[31:28], bus.ins[25:0], 2'b00};
    end else if (is_taken) begin
      next_pc = bus.PCp4 + br_off;
    end
    // Saturate rather than wrap; only reachable with the watchdog disabled.
    ret_inc = (ret_q == 16'hFFFF) ? ret_q : ret_q + 16'd1;
    wd_hit  = (MAX_INS != 16'd0) && (ret_inc == MAX_INS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= ENTRY;
      ret_q     <= 16'd0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT, FAULT: begin
          if (bus.start) begin
            state     <= RUN;
            pc_q      <= ENTRY;
            ret_q     <= 16'd0;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            ret_q <= ret_inc;
            // Halt wins over the watchdog and keeps pc pointing at the halt instruction.
            if (is_halt) begin
              state     <= HALT;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end else begin
              pc_q <= next_pc;
              if (wd_hit) begin
                state     <= FAULT;
                running_q <= 1'b0;
                fault_q   <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.PCin    = pc_q;
  assign bus.retired = ret_q;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;
  assign bus.fault   = fault_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_y_pc_seq.sv
// Bench for y_pc_seq: two instances (default watchdog and MAX_INS=4) run against a
// behavioural model; directed scenarios first, then randomized traffic, then async reset.
module tb_y_pc_seq;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_HALT  = 2;
  localparam int ST_FAULT = 3;

  localparam logic [31:0] SEQ    = 32'h20080001;
  localparam logic [31:0] HLT    = 32'h0000000C;
  localparam logic [31:0] BEQ_M2 = 32'h1000FFFE;
  localparam logic [31:0] LOOP   = 32'h1000FFFF;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y_pc_seq_if b0 ();
  y_pc_seq_if b1 ();
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  y_pc_seq dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .dbg_state(dbg0));
  y_pc_seq #(.ENTRY(32'd128), .MAX_INS(16'd4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(dbg1));

  // reference model state per lane
  int          m_st [2];
  logic [31:0] m_pc [2];
  logic [15:0] m_ret[2];
  logic [15:0] m_max[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] model_next_pc(input logic [31:0] ins, input logic [31:0] pcp4, input logic zero);
    int unsigned op;
    int off;
    op = int'(ins >> 26);
    if (op == 2 || op == 3) return (pcp4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if ((op == 4 && zero) || (op == 5 && !zero)) begin
      off = int'($signed(ins[15:0]));
      return pcp4 + 32'(off * 4);
    end
    return pcp4;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_st[l]  = ST_IDLE;
      m_pc[l]  = 32'd128;
      m_ret[l] = 16'd0;
    end
  endtask

  task automatic model_step(input int l, input logic s, input logic st, input logic [31:0] ins, input logic z);
    int cnt;
    if (m_st[l] != ST_RUN) begin
      if (s) begin
        m_st[l]  = ST_RUN;
        m_pc[l]  = 32'd128;
        m_ret[l] = 16'd0;
      end
    end else if (!st) begin
      cnt      = int'(m_ret[l]) + 1;
      m_ret[l] = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
      if (ins == HLT) begin
        m_st[l] = ST_HALT;
      end else begin
        m_pc[l] = model_next_pc(ins, m_pc[l] + 32'd4, z);
        if (m_max[l] != 16'd0 && m_ret[l] == m_max[l]) m_st[l] = ST_FAULT;
      end
    end
  endtask

  task automatic check_lane(input int l);
    logic [31:0] pc;
    logic [15:0] r;
    logic        ru, h, f;
    logic [1:0]  d;
    if (l == 0) begin
      pc = b0.PCin; r = b0.retired; ru = b0.running; h = b0.halted; f = b0.fault; d = dbg0;
    end else begin
      pc = b1.PCin; r = b1.retired; ru = b1.running; h = b1.halted; f = b1.fault; d = dbg1;
    end
    check_eq($sformatf("l%0d_pc", l), pc, m_pc[l]);
    check_eq($sformatf("l%0d_retired", l), {16'd0, r}, {16'd0, m_ret[l]});
    check_eq($sformatf("l%0d_running", l), {31'd0, ru}, {31'd0, m_st[l] == ST_RUN});
    check_eq($sformatf("l%0d_halted", l), {31'd0, h}, {31'd0, m_st[l] == ST_HALT});
    check_eq($sformatf("l%0d_fault", l), {31'd0, f}, {31'd0, m_st[l] == ST_FAULT});
    check_eq($sformatf("l%0d_dbg_known", l), {31'd0, (^d) !== 1'bx}, 32'd1);
  endtask

  // driver: apply one cycle of inputs at the negedge, advance the model, check at the next negedge
  task automatic tick(input logic s0, input logic st0, input logic [31:0] i0, input logic z0,
                      input logic s1, input logic st1, input logic [31:0] i1, input logic z1);
    b0.start = s0; b0.stall = st0; b0.ins = i0; b0.zero = z0; b0.PCp4 = m_pc[0] + 32'd4;
    b1.start = s1; b1.stall = st1; b1.ins = i1; b1.zero = z1; b1.PCp4 = m_pc[1] + 32'd4;
    if (rst_n) begin
      model_step(0, s0, st0, i0, z0);
      model_step(1, s1, st1, i1, z1);
    end
    @(negedge clk);
    check_lane(0);
    check_lane(1);
  endtask

  task automatic tick0(input logic s, input logic st, input logic [31:0] i, input logic z);
    tick(s, st, i, z, 1'b0, 1'b0, SEQ, 1'b0);
  endtask

  task automatic tick1(input logic s, input logic st, input logic [31:0] i, input logic z);
    tick(1'b0, 1'b0, SEQ, 1'b0, s, st, i, z);
  endtask

  function automatic logic [31:0] rand_ins();
    int unsigned k;
    logic [31:0] r;
    logic [15:0] off;
    k   = $urandom_range(0, 99);
    r   = $urandom();
    off = 16'($signed($urandom_range(0, 15)) - 8);
    if (k < 40) return {6'h08, r[25:0]};
    if (k < 65) return {(r[26] ? 6'h05 : 6'h04), r[25:16], off};
    if (k < 80) return {(r[26] ? 6'h03 : 6'h02), r[25:0]};
    if (k < 85) return HLT;
    return r;
  endfunction

  initial begin
    m_max[0] = 16'd1000;
    m_max[1] = 16'd4;
    model_reset();
    b0.start = 1'b0; b0.stall = 1'b0; b0.ins = SEQ; b0.zero = 1'b0; b0.PCp4 = 32'd132;
    b1.start = 1'b0; b1.stall = 1'b0; b1.ins = SEQ; b1.zero = 1'b0; b1.PCp4 = 32'd132;
    repeat (2) @(negedge clk);
    check_lane(0);
    check_lane(1);
    check_eq("reset_pc", b0.PCin, 32'd128);
    rst_n = 1'b1;
    tick0(1'b0, 1'b0, SEQ, 1'b0);

    // sequential run
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    check_eq("seq_pc0", b0.PCin, 32'd128);
    for (int k = 1; k <= 5; k++) begin
      tick0(1'b0, 1'b0, SEQ, 1'b0);
      check_eq($sformatf("seq_pc%0d", k), b0.PCin, 32'd128 + 32'(4 * k));
    end
    check_eq("seq_retired", {16'd0, b0.retired}, 32'd5);
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    check_eq("start_in_run_pc", b0.PCin, 32'd152);

    // branch taken / not taken
    tick0(1'b0, 1'b0, HLT, 1'b0);
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    check_eq("br_pre_pc", b0.PCin, 32'd136);
    tick0(1'b0, 1'b0, BEQ_M2, 1'b1);
    check_eq("beq_taken_pc", b0.PCin, 32'd132);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, BEQ_M2, 1'b0);
    check_eq("beq_nt_pc", b0.PCin, 32'd140);

    // jump then stall hold
    tick0(1'b0, 1'b0, HLT, 1'b0);
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, 32'h08000040, 1'b0);
    check_eq("jump_pc", b0.PCin, 32'h00000100);
    for (int k = 0; k < 3; k++) begin
      tick0(1'b1, 1'b1, 32'h08000040, 1'b1);
      check_eq("stall_pc", b0.PCin, 32'h00000100);
      check_eq("stall_retired", {16'd0, b0.retired}, 32'd2);
    end

    // wrap-around in both directions
    tick0(1'b0, 1'b0, 32'h10008000, 1'b1);
    check_eq("wrap_br_pc", b0.PCin, 32'hFFFE0104);
    tick0(1'b0, 1'b0, 32'h0BFFFFFF, 1'b0);
    check_eq("wrap_jump_pc", b0.PCin, 32'hFFFFFFFC);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    check_eq("wrap_seq_pc", b0.PCin, 32'h00000000);
    check_eq("wrap_no_fault", {31'd0, b0.fault}, 32'd0);

    // halt and restart
    tick0(1'b0, 1'b0, HLT, 1'b0);
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    for (int k = 0; k < 3; k++) tick0(1'b0, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, HLT, 1'b0);
    check_eq("halt_halted", {31'd0, b0.halted}, 32'd1);
    check_eq("halt_retired", {16'd0, b0.retired}, 32'd4);
    check_eq("halt_pc", b0.PCin, 32'd140);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    check_eq("halt_hold_pc", b0.PCin, 32'd140);
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    check_eq("restart_pc", b0.PCin, 32'd128);
    check_eq("restart_retired", {16'd0, b0.retired}, 32'd0);
    check_eq("restart_running", {31'd0, b0.running}, 32'd1);

    // watchdog on lane 1, then halt beating the watchdog
    tick1(1'b1, 1'b0, SEQ, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick1(1'b0, 1'b0, LOOP, 1'b1);
      check_eq($sformatf("wd_fault_%0d", k), {31'd0, b1.fault}, (k == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("wd_retired_%0d", k), {16'd0, b1.retired}, 32'(k));
      check_eq($sformatf("wd_pc_%0d", k), b1.PCin, 32'd128);
    end
    tick1(1'b1, 1'b0, SEQ, 1'b0);
    for (int k = 0; k < 3; k++) tick1(1'b0, 1'b0, LOOP, 1'b1);
    tick1(1'b0, 1'b0, HLT, 1'b0);
    check_eq("wd_halt_halted", {31'd0, b1.halted}, 32'd1);
    check_eq("wd_halt_fault", {31'd0, b1.fault}, 32'd0);
    check_eq("wd_halt_retired", {16'd0, b1.retired}, 32'd4);

    // randomized traffic on both lanes
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, rand_ins(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, rand_ins(), 1'($urandom_range(0, 1)));
    end

    // async reset in the middle of RUN
    tick0(1'b0, 1'b0, HLT, 1'b0);
    tick0(1'b1, 1'b0, SEQ, 1'b0);
    tick0(1'b0, 1'b0, SEQ, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pc", b0.PCin, 32'd128);
    check_eq("arst_running", {31'd0, b0.running}, 32'd0);
    check_eq("arst_retired", {16'd0, b0.retired}, 32'd0);
    check_lane(0);
    check_lane(1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, SEQ, 1'b0, 1'b0, 1'b0, SEQ, 1'b0);
      check_eq("post_rst_idle_run", {31'd0, b0.running}, 32'd0);
      check_eq("post_rst_idle_pc", b0.PCin, 32'd128);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
